// File: rtl/enc8_event_server.sv
// Event-to-index server: latches up to eight event lines into a pending set and
// presents them one at a time as a 3-bit code on a valid/ready port.
module enc8_event_server #(
    parameter int ROUND_ROBIN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ev_i,
    output logic [2:0] code_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       ovf_o,
    input  logic       ovf_clr_i,
    output logic       busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t     state_r;
    logic [7:0] pend_r;
    logic [2:0] last_r;

    logic [2:0] sel_s;
    logic       accept_s;
    logic       load_s;
    logic [7:0] take_s;
    logic       drop_s;

    // Lowest set index of req; 0 when req is empty (callers gate on |req).
    function automatic logic [2:0] pick_fixed(input logic [7:0] req);
        logic [2:0] idx;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx   = (!found && req[i]) ? 3'(i) : idx;
            found = found | req[i];
        end
        return idx;
    endfunction

    // Rotate so bit 0 is index last+1, take the lowest, then rotate the result back.
    function automatic logic [2:0] pick_rr(input logic [7:0] req, input logic [2:0] last);
        logic [15:0] dbl;
        logic [3:0]  shamt;
        logic [7:0]  rot;
        dbl   = {req, req};
        shamt = {1'b0, last} + 4'd1;
        rot   = 8'(dbl >> shamt);
        return last + 3'd1 + pick_fixed(rot);
    endfunction

    // Selection, load decision and take/overflow masks from registered state only.
    always_comb begin
        sel_s    = (ROUND_ROBIN != 0) ? pick_rr(pend_r, last_r) : pick_fixed(pend_r);
        accept_s = valid_o & ready_i;
        load_s   = (|pend_r) & ((state_r == IDLE) | accept_s);
        take_s   = load_s ? (8'd1 << sel_s) : 8'd0;
        drop_s   = |(ev_i & pend_r & ~take_s);
    end

    // Pending set, sticky overflow and the presentation FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r  <= 8'h00;
            code_o  <= 3'd0;
            valid_o <= 1'b0;
            ovf_o   <= 1'b0;
            last_r  <= 3'd7;
            state_r <= IDLE;
        end else begin
            pend_r <= (pend_r & ~take_s) | ev_i;
            ovf_o  <= drop_s | (ovf_o & ~ovf_clr_i);
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        code_o  <= sel_s;
                        last_r  <= sel_s;
                        valid_o <= 1'b1;
                        state_r <= SHOW;
                    end else begin
                        valid_o <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHOW: begin
                    if (load_s) begin
                        code_o  <= sel_s;
                        last_r  <= sel_s;
                        valid_o <= 1'b1;
                        state_r <= SHOW;
                    end else if (accept_s) begin
                        valid_o <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        valid_o <= 1'b1;
                        state_r <= SHOW;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (|pend_r) | valid_o;

endmodule

// File: tb/tb_enc8_event_server.sv
// Bench for enc8_event_server: fixed-priority and round-robin instances share stimulus
// and are compared each cycle with a set-based reference model plus directed tables.
module tb_enc8_event_server;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ev = 8'h00;
    logic       ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] code0, code1;
    logic       valid0, valid1, ovf0, ovf1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enc8_event_server #(.ROUND_ROBIN(0)) dut0 (
        .clk(clk), .rst(rst), .ev_i(ev), .code_o(code0), .valid_o(valid0),
        .ready_i(ready), .ovf_o(ovf0), .ovf_clr_i(ovf_clr), .busy_o(busy0)
    );

    enc8_event_server #(.ROUND_ROBIN(1)) dut1 (
        .clk(clk), .rst(rst), .ev_i(ev), .code_o(code1), .valid_o(valid1),
        .ready_i(ready), .ovf_o(ovf1), .ovf_clr_i(ovf_clr), .busy_o(busy1)
    );

    // Reference model: index 0 = fixed priority, index 1 = round robin.
    bit m_pend[2][8];
    int m_code[2];
    int m_last[2];
    bit m_valid[2];
    bit m_ovf[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_pick(input int d);
        for (int k = 1; k <= 8; k++) begin
            int j;
            j = (d == 1) ? (m_last[d] + k) % 8 : k - 1;
            if (m_pend[d][j]) return j;
        end
        return -1;
    endfunction

    function automatic bit m_busy(input int d);
        bit any;
        any = m_valid[d];
        for (int j = 0; j < 8; j++) any = any | m_pend[d][j];
        return any;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 8; j++) m_pend[d][j] = 1'b0;
            m_code[d]  = 0;
            m_last[d]  = 7;
            m_valid[d] = 1'b0;
            m_ovf[d]   = 1'b0;
        end
    endtask

    task automatic model_step(input logic [7:0] e, input bit r, input bit c);
        for (int d = 0; d < 2; d++) begin
            bit accept;
            bit lost;
            int idx;
            accept = m_valid[d] && r;
            lost   = 1'b0;
            idx    = -1;
            if (!m_valid[d] || accept) idx = m_pick(d);
            if (idx >= 0) begin
                m_code[d]       = idx;
                m_last[d]       = idx;
                m_valid[d]      = 1'b1;
                m_pend[d][idx]  = 1'b0;
            end else if (accept) begin
                m_valid[d] = 1'b0;
            end
            for (int j = 0; j < 8; j++) begin
                if (e[j]) begin
                    if (m_pend[d][j]) lost = 1'b1;
                    m_pend[d][j] = 1'b1;
                end
            end
            m_ovf[d] = lost || (m_ovf[d] && !c);
        end
    endtask

    task automatic compare_model();
        check("model code fixed", code0, m_code[0]);
        check("model valid fixed", valid0, m_valid[0]);
        check("model ovf fixed", ovf0, m_ovf[0]);
        check("model busy fixed", busy0, m_busy(0));
        check("model code rr", code1, m_code[1]);
        check("model valid rr", valid1, m_valid[1]);
        check("model ovf rr", ovf1, m_ovf[1]);
        check("model busy rr", busy1, m_busy(1));
    endtask

    // One clock: drive at negedge, model advances at posedge, compare at next negedge.
    task automatic cycle(input logic [7:0] e, input bit r, input bit c);
        ev      = e;
        ready   = r;
        ovf_clr = c;
        @(posedge clk);
        model_step(e, r, c);
        @(negedge clk);
        compare_model();
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear immediately.
    task automatic do_reset();
        ev      = 8'h00;
        ready   = 1'b0;
        ovf_clr = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("rst code fixed", code0, 0);
        check("rst valid fixed", valid0, 0);
        check("rst ovf fixed", ovf0, 0);
        check("rst busy fixed", busy0, 0);
        check("rst code rr", code1, 0);
        check("rst valid rr", valid1, 0);
        check("rst ovf rr", ovf1, 0);
        check("rst busy rr", busy1, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic hc(input string name, input bit v, input int c, input bit o, input bit b);
        check({name, " valid fixed"}, valid0, v);
        check({name, " code fixed"}, code0, c);
        check({name, " ovf fixed"}, ovf0, o);
        check({name, " busy fixed"}, busy0, b);
        check({name, " valid rr"}, valid1, v);
        check({name, " code rr"}, code1, c);
        check({name, " ovf rr"}, ovf1, o);
        check({name, " busy rr"}, busy1, b);
    endtask

    typedef struct {
        bit         rst_first;
        logic [7:0] ev;
        bit         rdy;
        bit         v;
        int         c0;
        int         c1;
        bit         b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rf, input logic [7:0] e, input bit r,
                                input bit v, input int c0, input int c1, input bit b);
        vec_t t;
        t.rst_first = rf;
        t.ev        = e;
        t.rdy       = r;
        t.v         = v;
        t.c0        = c0;
        t.c1        = c1;
        t.b         = b;
        return t;
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Single event latency after reset.
        vecs.push_back(mk(1, 8'h20, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 5, 5, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 5, 5, 0));
        // Backpressure on bits 1,4,7; round robin resumes after index 5.
        vecs.push_back(mk(0, 8'h92, 0, 0, 5, 5, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 8'h00, 0, 1, 1, 7, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 4, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 7, 4, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 7, 4, 0));
        // All eight events back-to-back from a fresh reset.
        vecs.push_back(mk(1, 8'hFF, 1, 0, 0, 0, 1));
        for (int k = 0; k < 8; k++) vecs.push_back(mk(0, 8'h00, 1, 1, k, k, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 7, 7, 0));
        // 0x81 with last=7, then a lone 0 to move last to 0, then 0x81 again.
        vecs.push_back(mk(0, 8'h81, 1, 0, 7, 7, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 7, 7, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 7, 7, 0));
        vecs.push_back(mk(0, 8'h01, 1, 0, 7, 7, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h81, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 7, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 7, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 7, 0, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            cycle(vecs[i].ev, vecs[i].rdy, 1'b0);
            check($sformatf("vec%0d valid fixed", i), valid0, vecs[i].v);
            check($sformatf("vec%0d valid rr", i), valid1, vecs[i].v);
            check($sformatf("vec%0d code fixed", i), code0, vecs[i].c0);
            check($sformatf("vec%0d code rr", i), code1, vecs[i].c1);
            check($sformatf("vec%0d busy fixed", i), busy0, vecs[i].b);
            check($sformatf("vec%0d busy rr", i), busy1, vecs[i].b);
            check($sformatf("vec%0d ovf fixed", i), ovf0, 0);
        end

        // Overflow: re-pend on own take, drop while pending, clear, clear-vs-set.
        do_reset();
        cycle(8'h08, 1'b0, 1'b0);  hc("ovf a", 0, 0, 0, 1);
        cycle(8'h08, 1'b0, 1'b0);  hc("ovf b", 1, 3, 0, 1);
        cycle(8'h08, 1'b0, 1'b0);  hc("ovf c", 1, 3, 1, 1);
        cycle(8'h00, 1'b0, 1'b0);  hc("ovf d", 1, 3, 1, 1);
        cycle(8'h00, 1'b0, 1'b1);  hc("ovf e", 1, 3, 0, 1);
        cycle(8'h08, 1'b0, 1'b1);  hc("ovf f", 1, 3, 1, 1);

        // Set-wins on the loading edge from IDLE.
        do_reset();
        cycle(8'h04, 1'b0, 1'b0);  hc("setwin a", 0, 0, 0, 1);
        cycle(8'h04, 1'b0, 1'b0);  hc("setwin b", 1, 2, 0, 1);
        cycle(8'h00, 1'b1, 1'b0);  hc("setwin c", 1, 2, 0, 1);
        cycle(8'h00, 1'b1, 1'b0);  hc("setwin d", 0, 2, 0, 0);

        // Reset while presenting with 0xF0 pending.
        do_reset();
        cycle(8'h10, 1'b0, 1'b0);
        cycle(8'hF0, 1'b0, 1'b0);  hc("midrst a", 1, 4, 0, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1'b1, 1'b0);
            hc("midrst b", 0, 0, 0, 0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] e;
            e = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) e = 8'h00;
            if ($urandom_range(0, 699) == 0) do_reset();
            cycle(e, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
